// File: rtl/alk_pkg.sv
// Shared constants and step-select encoding for the ALK loop-iteration controller.
package alk_pkg;

   localparam int ALK_LOOP_W = 6;

   localparam logic [ALK_LOOP_W-1:0] ALK_STEP_FAST = 6'd2;
   localparam logic [ALK_LOOP_W-1:0] ALK_STEP_SLOW = 6'd1;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_SLOW = 2'd1,
      STEP_FAST = 2'd2
   } step_e;

endpackage

// File: rtl/alkloopctl.sv
// M/D loop counter: load or step updates all outputs on the same edge, every output straight from a flop.
// stall_h freezes every register, loads included; there is no other backpressure.
module alkloopctl
   import alk_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_l,
   input  logic                  stall_h,
   input  logic                  ld_loop_h,
   input  logic [ALK_LOOP_W-1:0] loop_init_h,
   input  logic                  op_sign_h,
   input  logic                  muldiv_fast_l,
   input  logic                  mul_l,
   input  logic                  div_l,
   output logic                  loop_flag_h,
   output logic                  loop_last_h,
   output logic                  loop_odd_h,
   output logic                  md_sign_h,
   output logic [ALK_LOOP_W-1:0] loop_count_h
);

   logic [ALK_LOOP_W-1:0] cnt;
   logic [ALK_LOOP_W-1:0] cnt_next;
   logic [ALK_LOOP_W-1:0] step_amt;
   logic                  odd_next;
   logic                  sign_next;
   step_e                 step_sel;

   // Steps only count while running; a load masks any step in the same cycle.
   always_comb begin
      step_sel = STEP_NONE;
      if (!ld_loop_h && (cnt != '0)) begin
         if (!muldiv_fast_l)
            step_sel = STEP_FAST;
         else if (!mul_l || !div_l)
            step_sel = STEP_SLOW;
      end
   end

   always_comb begin
      step_amt  = '0;
      cnt_next  = cnt;
      odd_next  = loop_odd_h;
      sign_next = md_sign_h;
      case (step_sel)
         STEP_FAST: step_amt = ALK_STEP_FAST;
         STEP_SLOW: step_amt = ALK_STEP_SLOW;
         default:   step_amt = '0;
      endcase
      if (ld_loop_h) begin
         cnt_next  = loop_init_h;
         odd_next  = 1'b0;
         sign_next = op_sign_h;
      end else begin
         // Saturate at zero; a fast step from 1 is the odd-length tail.
         cnt_next = (cnt < step_amt) ? '0 : cnt - step_amt;
         if ((step_sel == STEP_FAST) && (cnt == 6'd1))
            odd_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         cnt         <= '0;
         loop_flag_h <= 1'b0;
         loop_last_h <= 1'b0;
         loop_odd_h  <= 1'b0;
         md_sign_h   <= 1'b0;
      end else if (!stall_h) begin
         cnt         <= cnt_next;
         loop_flag_h <= (cnt_next != '0);
         loop_last_h <= (cnt_next == 6'd1) || (cnt_next == 6'd2);
         loop_odd_h  <= odd_next;
         md_sign_h   <= sign_next;
      end
   end

   assign loop_count_h = cnt;

endmodule

// File: tb/tb_alkloopctl.sv
// Randomized and directed bench for alkloopctl against a plain-arithmetic loop model.
module tb_alkloopctl;

   logic       clk = 1'b0;
   logic       reset_l;
   logic       stall_h;
   logic       ld_loop_h;
   logic [5:0] loop_init_h;
   logic       op_sign_h;
   logic       muldiv_fast_l;
   logic       mul_l;
   logic       div_l;
   logic       loop_flag_h;
   logic       loop_last_h;
   logic       loop_odd_h;
   logic       md_sign_h;
   logic [5:0] loop_count_h;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: remaining iterations, odd-tail flag, captured sign.
   int m_cnt  = 0;
   int m_odd  = 0;
   int m_sign = 0;

   alkloopctl dut (
      .clk          (clk),
      .reset_l      (reset_l),
      .stall_h      (stall_h),
      .ld_loop_h    (ld_loop_h),
      .loop_init_h  (loop_init_h),
      .op_sign_h    (op_sign_h),
      .muldiv_fast_l(muldiv_fast_l),
      .mul_l        (mul_l),
      .div_l        (div_l),
      .loop_flag_h  (loop_flag_h),
      .loop_last_h  (loop_last_h),
      .loop_odd_h   (loop_odd_h),
      .md_sign_h    (md_sign_h),
      .loop_count_h (loop_count_h)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_count"}, int'(loop_count_h), m_cnt);
      chk({tag, "_flag"},  int'(loop_flag_h),  (m_cnt != 0) ? 1 : 0);
      chk({tag, "_last"},  int'(loop_last_h),  (m_cnt == 1 || m_cnt == 2) ? 1 : 0);
      chk({tag, "_odd"},   int'(loop_odd_h),   m_odd);
      chk({tag, "_sign"},  int'(md_sign_h),    m_sign);
   endtask

   // Drive one microcycle (called just after a falling edge), advance the model, check after the next falling edge.
   task automatic cyc(input string tag, input bit stall, input bit ld, input int init,
                      input bit sign, input bit fast_l, input bit m_l, input bit d_l);
      stall_h       = stall;
      ld_loop_h     = ld;
      loop_init_h   = init[5:0];
      op_sign_h     = sign;
      muldiv_fast_l = fast_l;
      mul_l         = m_l;
      div_l         = d_l;
      if (!stall) begin
         if (ld) begin
            m_cnt  = init;
            m_sign = sign;
            m_odd  = 0;
         end else if (m_cnt > 0 && !fast_l) begin
            if (m_cnt == 1) m_odd = 1;
            m_cnt = (m_cnt >= 2) ? m_cnt - 2 : 0;
         end else if (m_cnt > 0 && (!m_l || !d_l)) begin
            m_cnt = m_cnt - 1;
         end
      end
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      cyc(tag, 0, 0, 0, 0, 1, 1, 1);
   endtask

   initial begin
      reset_l = 1'b0;
      stall_h = 0; ld_loop_h = 0; loop_init_h = 0; op_sign_h = 0;
      muldiv_fast_l = 1; mul_l = 1; div_l = 1;
      @(negedge clk);
      check_all("reset");
      reset_l = 1'b1;
      idle("post_reset");

      // Fast loop of 32: 16 fast cycles to reach zero.
      cyc("ld32", 0, 1, 32, 0, 1, 1, 1);
      chk("ld32_count_lit", int'(loop_count_h), 32);
      for (int i = 1; i <= 16; i++) begin
         cyc("fast32", 0, 0, 0, 0, 0, 1, 1);
         chk("fast32_count_lit", int'(loop_count_h), 32 - 2 * i);
      end
      chk("fast32_flag_drop", int'(loop_flag_h), 0);
      chk("fast32_odd_clear", int'(loop_odd_h), 0);

      // Odd fast loop: 5,3,1,0 with the odd flag on the last step.
      cyc("ld5", 0, 1, 5, 0, 1, 1, 1);
      for (int i = 0; i < 3; i++) cyc("fast5", 0, 0, 0, 0, 0, 1, 1);
      chk("odd5_set", int'(loop_odd_h), 1);
      idle("odd5_hold");
      cyc("odd5_idle_fast", 0, 0, 0, 0, 0, 1, 1);
      chk("odd5_sticky", int'(loop_odd_h), 1);
      cyc("ld_clear_odd", 0, 1, 0, 0, 1, 1, 1);
      chk("odd_cleared_by_load", int'(loop_odd_h), 0);

      // Slow divide loop with one stalled cycle.
      cyc("ld3", 0, 1, 3, 0, 1, 1, 1);
      cyc("slow3_a", 0, 0, 0, 0, 1, 1, 0);
      cyc("slow3_stall", 1, 0, 0, 0, 1, 1, 0);
      chk("slow3_stall_lit", int'(loop_count_h), 2);
      cyc("slow3_b", 0, 0, 0, 0, 1, 1, 0);
      chk("slow3_b_lit", int'(loop_count_h), 1);
      cyc("slow3_c", 0, 0, 0, 0, 1, 1, 0);
      chk("slow3_c_lit", int'(loop_count_h), 0);

      // Load beats a simultaneous fast step.
      cyc("ld4", 0, 1, 4, 0, 1, 1, 1);
      cyc("ld_prio", 0, 1, 9, 1, 0, 1, 1);
      chk("ld_prio_count_lit", int'(loop_count_h), 9);
      chk("ld_prio_sign_lit", int'(md_sign_h), 1);
      cyc("stall_ld", 1, 1, 20, 0, 1, 1, 1);
      chk("stall_ld_lit", int'(loop_count_h), 9);

      // Step requests in IDLE do nothing.
      cyc("ld0", 0, 1, 0, 0, 1, 1, 1);
      for (int i = 0; i < 4; i++) cyc("idle_steps", 0, 0, 0, 0, 0, 0, 1);
      chk("idle_odd_lit", int'(loop_odd_h), 0);
      chk("idle_flag_lit", int'(loop_flag_h), 0);

      // Randomized mix of loads, steps and stalls.
      for (int i = 0; i < 600; i++) begin
         bit ld, st;
         int init;
         ld   = ($urandom_range(0, 9) == 0);
         st   = ($urandom_range(0, 7) == 0);
         init = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 63);
         cyc("rand", st, ld, init, 1'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(0, 2) != 0));
      end

      // Asynchronous reset mid-run at count 17.
      cyc("ld17", 0, 1, 17, 1, 1, 1, 1);
      cyc("ld17_slow", 0, 0, 0, 0, 1, 0, 1);
      #2;
      reset_l = 1'b0;
      #1;
      m_cnt = 0; m_odd = 0; m_sign = 0;
      check_all("async_reset");
      @(negedge clk);
      reset_l = 1'b1;
      idle("after_reset");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alkloopctl.md
# alkloopctl

Loop-iteration controller for the DC615 ALK on the DPM. Holds the multiply/divide step count and generates the registered `loop_flag_h` consumed by the ALPCTL decoder. The decoder uses `loop_flag_h` to qualify `muldiv_fast_l`; its decoded `muldiv_fast_l`, `mul_l` and `div_l` return here to advance the count. Also supplies the loop-state bits read out by the WB_LOOPF flag group.

## Interface
- No parameters. Count width is fixed at 6 bits.
- `clk`  in  1  microcycle clock; all state changes on the rising edge.
- `reset_l`  in  1  asynchronous, active-low reset.
- `stall_h`  in  1  microcycle stall; freezes all state, including loads.
- `ld_loop_h`  in  1  load the loop counter this cycle.
- `loop_init_h`  in  6  iteration count to load.
- `op_sign_h`  in  1  operand sign, captured on load.
- `muldiv_fast_l`  in  1  fast M/D loop cycle (two bits per cycle), from the decoder.
- `mul_l`  in  1  multiply step, from the decoder.
- `div_l`  in  1  divide step, from the decoder.
- `loop_flag_h`  out  1  loop still running (count ≠ 0), registered.
- `loop_last_h`  out  1  count is 1 or 2, i.e. the final step is pending; registered.
- `loop_odd_h`  out  1  sticky flag: a fast step was taken with count = 1.
- `md_sign_h`  out  1  captured operand sign.
- `loop_count_h`  out  6  current count, for WB_LOOPF readout.

## Operation
- Counter `cnt[5:0]`. Machine states are implicit:
  - IDLE: `cnt == 0`.
  - RUN: `cnt != 0`.
- Per-cycle priority when `stall_h == 0`:
  1. `ld_loop_h == 1`:
     - `cnt ← loop_init_h`
     - `md_sign_h ← op_sign_h`
     - `loop_odd_h ← 0`
     - Any step request in the same cycle is ignored.
  2. Otherwise, if in RUN and `muldiv_fast_l == 0`:
     - If `cnt ≥ 2`: `cnt ← cnt − 2`.
     - If `cnt == 1`: `cnt ← 0` and `loop_odd_h ← 1`.
  3. Otherwise, if in RUN and (`mul_l == 0` or `div_l == 0`) and `muldiv_fast_l == 1`:
     - Slow step: `cnt ← cnt − 1`.
  4. Otherwise: hold.
- In IDLE, step requests are ignored. The counter never wraps below 0.
- Loading 0 moves the block directly to IDLE and leaves `loop_flag_h` at 0.
- `loop_flag_h`, `loop_last_h` and `loop_count_h` are registered copies computed from the next-state count. They therefore reflect the new count in the cycle after the update.
- `loop_last_h = (cnt_next == 1) | (cnt_next == 2)`.
- `stall_h == 1` holds every register, including over `ld_loop_h`.
- Reset, asynchronous: `cnt = 0`, `loop_flag_h = 0`, `loop_last_h = 0`, `loop_odd_h = 0`, `md_sign_h = 0`, `loop_count_h = 0`.
- Reset asserted mid-loop aborts the loop immediately, without waiting for a clock edge.

## Timing
- Load to flag: `loop_flag_h` rises on the edge that performs a nonzero load, so it is valid one cycle later.
- The fast-step decode depends on `loop_flag_h` combinationally in the decoder. `loop_flag_h` must come directly from a flop: no combinational path from any input to any output, which prevents a loop.
- Step to flag drop: the edge that takes `cnt` to 0 clears `loop_flag_h`. The next microcycle sees `loop_flag_h = 0`, so the decoder suppresses `muldiv_fast_l`.
- Latency:
  - 32 fast iterations: loading 32 gives 16 fast cycles.
  - Loading 31 gives 16 fast cycles, with `loop_odd_h = 1` set on the last one.

## Structure
- Shared package `alk_pkg` holds:
  - the count-width constant `ALK_LOOP_W = 6`;
  - the step-size constants `ALK_STEP_FAST = 2` and `ALK_STEP_SLOW = 1`.
- A single flat module; no sub-module is needed.
- A step-select decode (fast/slow/none) is the only combinational core, feeding one next-state adder/saturator.

## Test plan
- Reset: assert `reset_l = 0` mid-RUN with `cnt = 17`. Without a clock edge, all outputs must read 0.
- Fast loop: load 32, then drive `muldiv_fast_l = 0` every cycle.
  - `loop_count_h` steps 32, 30, …, 2, 0.
  - `loop_last_h` is high once `cnt = 2`.
  - `loop_flag_h` drops after exactly 16 steps.
  - `loop_odd_h` stays 0.
- Odd fast loop: load 5, drive fast steps.
  - Count sequence 5, 3, 1, 0.
  - `loop_odd_h = 1` after the third step and remains set until the next load.
- Slow loop with stall: load 3 and drive `div_l = 0`, with `stall_h = 1` on the second cycle. The count holds at 2 for that cycle, then goes to 1 and then 0.
- Load priority: with `cnt = 4`, assert `ld_loop_h` with `loop_init_h = 9`, `op_sign_h = 1` and `muldiv_fast_l = 0` together. Result: `cnt = 9`, `md_sign_h = 1`, no decrement.
- Idle steps: with `cnt = 0`, drive `mul_l = 0` and `muldiv_fast_l = 0` for 4 cycles. `cnt` stays 0, `loop_flag_h` stays 0, and `loop_odd_h` is not set.
